dmem_resp: RTL

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data memory that stalls the pipeline through IDLE -> BUSY -> RESP.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned halfword/word accesses fault instead of aligning).
module dmem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [1:0]  dbg_state_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a request is accepted in IDLE when MemRead|MemWrite is high (stall rises in that
  // same cycle); stall stays high through BUSY; done (and fault) pulse for exactly one RESP cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;
  logic          store_q;
  logic [31:0]   rdata_q;

  logic          latch, commit, trap;
  logic [31:0]   mem_word, ld_val, st_data, merged;
  logic [3:0]    be;
  logic          mem_we;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          unused_addr;

  logic [31:0]   mem [DEPTH_WORDS];

  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          stall   = 1'b1;
          latch   = 1'b1;
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic is_half, is_word;
  assign is_half = (funct3_q == 3'b001) || (funct3_q == 3'b101);
  assign is_word = (funct3_q == 3'b010);
  assign trap    = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
  assign fault   = done && trap;
`else
  assign trap  = 1'b0;
  assign fault = 1'b0;
`endif

  assign mem_word = mem[addr_q[AW+1:2]];
  assign ld_byte  = mem_word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half  = addr_q[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    ld_val = 32'd0;
    case (funct3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = mem_word;
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = 32'd0;
    endcase
    if (trap) ld_val = 32'd0;
  end

  // Sub-word stores replicate the data across lanes; byte enables pick the lanes to keep.
  always_comb begin
    be      = 4'b0000;
    st_data = wdata_q;
    case (funct3_q)
      3'b000: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? st_data[8*i +: 8] : mem_word[8*i +: 8];
    end
  end

  assign mem_we = commit && store_q && !trap && !rst && (be != 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      store_q  <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q   <= addr[AW+1:0];
        wdata_q  <= wdata;
        funct3_q <= funct3;
        store_q  <= MemWrite;
      end
      if (commit && !store_q) rdata_q <= ld_val;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q[AW+1:2]] <= merged;
  end

  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;
endmodule
